// File: rtl/handshake_tx_pkg.sv
// Shared types and defaults for the four-phase handshake transmitter.
package handshake_tx_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    REL  = 2'd2
  } state_t;

  localparam int unsigned DEF_WIDTH       = 8;
  localparam int unsigned DEF_SYNC_STAGES = 3;
  localparam int unsigned DEF_TIMEOUT     = 255;
  // Wide enough for the largest TIMEOUT (65535)
  localparam int unsigned CNT_W           = 16;

endpackage

// File: rtl/handshake_tx_if.sv
// Local request/payload/status bundle plus the far-end ack level.
interface handshake_tx_if
  import handshake_tx_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
) ();

  logic             send;
  logic [WIDTH-1:0] data_in;
  logic             ack_nsyn;
  logic             req;
  logic [WIDTH-1:0] data_out;
  logic             busy;
  logic             done;
  logic             drop;
  logic             err;

  modport master (
    input  send, data_in, ack_nsyn,
    output req, data_out, busy, done, drop, err
  );

  modport slave (
    output send, data_in, ack_nsyn,
    input  req, data_out, busy, done, drop, err
  );

endinterface

// File: rtl/sync_nstage.sv
// N-flop level synchronizer; q follows d after STAGES rising edges.
module sync_nstage #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sr;

  always_ff @(posedge clk) begin
    if (rst) sr <= '0;
    else     sr <= {sr[STAGES-2:0], d};
  end

  assign q = sr[STAGES-1];

endmodule

// File: rtl/handshake_tx.sv
// Four-phase request/ack transmitter with payload hold, busy-drop and timeout abort.
module handshake_tx
  import handshake_tx_pkg::*;
#(
  parameter int unsigned WIDTH       = DEF_WIDTH,
  parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int unsigned TIMEOUT     = DEF_TIMEOUT
) (
  input logic            clk,
  input logic            rst,
  handshake_tx_if.master bus
);

  // Abort fires on the edge that completes TIMEOUT cycles spent in REQ
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  logic ack_syn;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             abort_q, abort_nxt;
  logic             req_q, req_nxt;
  logic [WIDTH-1:0] data_q, data_nxt;
  logic             busy_q, busy_nxt;
  logic             done_q, done_nxt;
  logic             drop_q, drop_nxt;
  logic             err_q, err_nxt;

  sync_nstage #(.STAGES(SYNC_STAGES)) u_ack_sync (
    .clk (clk),
    .rst (rst),
    .d   (bus.ack_nsyn),
    .q   (ack_syn)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      abort_q <= 1'b0;
      req_q   <= 1'b0;
      data_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      drop_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      abort_q <= abort_nxt;
      req_q   <= req_nxt;
      data_q  <= data_nxt;
      busy_q  <= busy_nxt;
      done_q  <= done_nxt;
      drop_q  <= drop_nxt;
      err_q   <= err_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    abort_nxt = abort_q;
    req_nxt   = req_q;
    data_nxt  = data_q;
    done_nxt  = 1'b0;
    drop_nxt  = 1'b0;
    err_nxt   = 1'b0;

    unique case (state)
      IDLE: begin
        if (bus.send) begin
          state_nxt = REQ;
          req_nxt   = 1'b1;
          data_nxt  = bus.data_in;
          cnt_nxt   = '0;
          abort_nxt = 1'b0;
        end
      end
      REQ: begin
        drop_nxt = bus.send;
        if (ack_syn) begin
          state_nxt = REL;
          req_nxt   = 1'b0;
        end else if (cnt >= CNT_LAST) begin
          state_nxt = REL;
          req_nxt   = 1'b0;
          err_nxt   = 1'b1;
          abort_nxt = 1'b1;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      REL: begin
        drop_nxt = bus.send;
        // An aborted transfer still waits out the ack release, but silently
        if (!ack_syn) begin
          state_nxt = IDLE;
          done_nxt  = ~abort_q;
        end
      end
      default: begin
        state_nxt = IDLE;
        req_nxt   = 1'b0;
      end
    endcase

    busy_nxt = (state_nxt != IDLE);
  end

  assign bus.req      = req_q;
  assign bus.data_out = data_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.drop     = drop_q;
  assign bus.err      = err_q;

endmodule

// File: tb/tb_handshake_tx.sv
// Scoreboarded bench for handshake_tx: transfers, drop, timeout, reset, stale ack, glitches.
module tb_handshake_tx;
  import handshake_tx_pkg::*;

  localparam int unsigned W    = 8;
  localparam int unsigned SYNC = 3;
  localparam int unsigned TO   = 10;

  typedef struct packed {
    logic [W-1:0] data;
    logic         is_err;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  logic far_en, far_ack, man_ack, mon_en;
  int   far_cnt;

  handshake_tx_if #(.WIDTH(W)) bus ();

  handshake_tx #(.WIDTH(W), .SYNC_STAGES(SYNC), .TIMEOUT(TO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  assign bus.ack_nsyn = far_en ? far_ack : man_ack;

  int   n_vec = 0;
  int   n_err = 0;
  exp_t sb[$];
  exp_t e_mon;
  int   done_cnt = 0, err_cnt = 0, drop_cnt = 0;
  logic req_d = 1'b0, done_d = 1'b0, err_d = 1'b0, drop_d = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic push_exp(input logic [W-1:0] d, input logic e);
    exp_t x;
    x.data   = d;
    x.is_err = e;
    sb.push_back(x);
  endtask

  // Far-end receiver: ack 2 cycles after seeing req, release 2 cycles after req falls
  always @(negedge clk) begin
    if (rst === 1'b1 && !mon_en) begin
      far_ack = 1'b0;
      far_cnt = 0;
    end else if (far_en) begin
      if (bus.req && !far_ack) begin
        if (far_cnt == 1) begin far_ack = 1'b1; far_cnt = 0; end
        else far_cnt++;
      end else if (!bus.req && far_ack) begin
        if (far_cnt == 1) begin far_ack = 1'b0; far_cnt = 0; end
        else far_cnt++;
      end else begin
        far_cnt = 0;
      end
    end
  end

  // Output monitor: scoreboard pops on done/err, pulse-width and X checks
  always @(negedge clk) begin
    if (mon_en && !rst) begin
      chk("no_x", 32'($isunknown({bus.req, bus.data_out, bus.busy, bus.done, bus.drop, bus.err})), 32'(0));
      chk("state_legal", 32'(dut.state inside {IDLE, REQ, REL}), 32'(1));
      if (bus.req && !req_d) begin
        if (sb.size() > 0) chk("data_on_req", 32'(bus.data_out), 32'(sb[0].data));
        else               chk("unexpected_req", 32'(1), 32'(0));
      end
      if (bus.done || bus.err) begin
        if (sb.size() > 0) begin
          e_mon = sb.pop_front();
          chk("outcome_is_err", 32'(bus.err), 32'(e_mon.is_err));
          chk("data_at_end", 32'(bus.data_out), 32'(e_mon.data));
        end else begin
          chk("unexpected_end", 32'(1), 32'(0));
        end
      end
      if (bus.done) begin chk("done_1cyc", 32'(done_d), 32'(0)); done_cnt++; end
      if (bus.err)  begin chk("err_1cyc",  32'(err_d),  32'(0)); err_cnt++;  end
      if (bus.drop) begin chk("drop_1cyc", 32'(drop_d), 32'(0)); drop_cnt++; end
    end
    req_d  = bus.req;
    done_d = bus.done;
    err_d  = bus.err;
    drop_d = bus.drop;
  end

  task automatic wait_idle(input int budget);
    int n = 0;
    while ((bus.busy || sb.size() != 0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (bus.busy || sb.size() != 0) chk("wait_idle_expired", 32'(1), 32'(0));
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (!bus.done && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (!bus.done) chk("wait_done_expired", 32'(1), 32'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int d0, e0;
    rst = 1'b1; bus.send = 1'b0; bus.data_in = '0;
    far_en = 1'b1; far_ack = 1'b0; man_ack = 1'b0; mon_en = 1'b0; far_cnt = 0;
    repeat (3) @(negedge clk);

    chk("rst_req",   32'(bus.req), 32'(0));
    chk("rst_busy",  32'(bus.busy), 32'(0));
    chk("rst_done",  32'(bus.done), 32'(0));
    chk("rst_drop",  32'(bus.drop), 32'(0));
    chk("rst_err",   32'(bus.err), 32'(0));
    chk("rst_data",  32'(bus.data_out), 32'(0));
    chk("rst_state", 32'(dut.state), 32'(IDLE));
    chk("rst_cnt",   32'(dut.cnt), 32'(0));
    chk("rst_sync",  32'(dut.u_ack_sync.sr), 32'(0));
    rst = 1'b0; mon_en = 1'b1;
    @(negedge clk);

    // Basic transfer with a send issued while busy
    d0 = done_cnt; e0 = err_cnt;
    bus.send = 1'b1; bus.data_in = 8'hA5; push_exp(8'hA5, 1'b0);
    @(negedge clk);
    bus.send = 1'b0;
    chk("basic_req",  32'(bus.req), 32'(1));
    chk("basic_data", 32'(bus.data_out), 32'(8'hA5));
    chk("basic_busy", 32'(bus.busy), 32'(1));
    bus.send = 1'b1; bus.data_in = 8'h3C;
    @(negedge clk);
    bus.send = 1'b0;
    chk("busy_drop",     32'(bus.drop), 32'(1));
    chk("busy_data_kept", 32'(bus.data_out), 32'(8'hA5));
    chk("busy_req_kept",  32'(bus.req), 32'(1));
    @(negedge clk);
    chk("busy_drop_clear", 32'(bus.drop), 32'(0));
    wait_idle(60);
    chk("basic_one_done", 32'(done_cnt - d0), 32'(1));
    chk("basic_no_err",   32'(err_cnt - e0), 32'(0));
    chk("basic_idle",     32'(bus.busy), 32'(0));
    chk("idle_data_hold", 32'(bus.data_out), 32'(8'hA5));

    // Back-to-back: send in the done cycle, then measure ack-to-req latency
    bus.send = 1'b1; bus.data_in = 8'h11; push_exp(8'h11, 1'b0);
    @(negedge clk);
    bus.send = 1'b0;
    wait_done(60);
    bus.send = 1'b1; bus.data_in = 8'h5A; push_exp(8'h5A, 1'b0);
    @(negedge clk);
    bus.send = 1'b0;
    chk("b2b_req",  32'(bus.req), 32'(1));
    chk("b2b_data", 32'(bus.data_out), 32'(8'h5A));
    n = 0;
    while (bus.req && n < 30) begin @(negedge clk); n++; end
    chk("req_hold_cycles", 32'(n), 32'(2 + SYNC));
    wait_idle(60);

    // Timeout with ack never arriving
    far_en = 1'b0; man_ack = 1'b0;
    d0 = done_cnt; e0 = err_cnt;
    bus.send = 1'b1; bus.data_in = 8'h77; push_exp(8'h77, 1'b1);
    @(negedge clk);
    bus.send = 1'b0;
    chk("to_req", 32'(bus.req), 32'(1));
    n = 0;
    while (!bus.err && n < 40) begin @(negedge clk); n++; end
    chk("to_cycles",   32'(n), 32'(TO));
    chk("to_req_low",  32'(bus.req), 32'(0));
    chk("to_no_done",  32'(bus.done), 32'(0));
    wait_idle(20);
    repeat (3) @(negedge clk);
    chk("to_one_err",   32'(err_cnt - e0), 32'(1));
    chk("to_done_none", 32'(done_cnt - d0), 32'(0));

    // Reset in the middle of REQ
    far_en = 1'b1;
    d0 = done_cnt; e0 = err_cnt;
    bus.send = 1'b1; bus.data_in = 8'h99; push_exp(8'h99, 1'b0);
    @(negedge clk);
    bus.send = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    sb.delete();
    chk("mid_rst_req",  32'(bus.req), 32'(0));
    chk("mid_rst_busy", 32'(bus.busy), 32'(0));
    chk("mid_rst_data", 32'(bus.data_out), 32'(0));
    repeat (12) @(negedge clk);
    chk("mid_rst_no_done", 32'(done_cnt - d0), 32'(0));
    chk("mid_rst_no_err",  32'(err_cnt - e0), 32'(0));

    // Stale ack already high on entry to REQ
    man_ack = 1'b1; far_en = 1'b0;
    repeat (SYNC + 2) @(negedge clk);
    d0 = done_cnt;
    bus.send = 1'b1; bus.data_in = 8'h42; push_exp(8'h42, 1'b0);
    @(negedge clk);
    bus.send = 1'b0;
    chk("stale_req", 32'(bus.req), 32'(1));
    @(negedge clk);
    chk("stale_req_fall", 32'(bus.req), 32'(0));
    repeat (3) @(negedge clk);
    chk("stale_rel_wait", 32'(bus.busy), 32'(1));
    man_ack = 1'b0;
    wait_idle(20);
    chk("stale_done", 32'(done_cnt - d0), 32'(1));

    // Sub-cycle ack glitch that no edge samples: must time out
    d0 = done_cnt; e0 = err_cnt;
    bus.send = 1'b1; bus.data_in = 8'h0F; push_exp(8'h0F, 1'b1);
    @(negedge clk);
    bus.send = 1'b0;
    @(negedge clk);
    man_ack = 1'b1;
    #2 man_ack = 1'b0;
    wait_idle(40);
    chk("glitch_miss_err",  32'(err_cnt - e0), 32'(1));
    chk("glitch_miss_done", 32'(done_cnt - d0), 32'(0));

    // Full-cycle ack pulse that the synchronizer captures
    d0 = done_cnt; e0 = err_cnt;
    bus.send = 1'b1; bus.data_in = 8'hF0; push_exp(8'hF0, 1'b0);
    @(negedge clk);
    bus.send = 1'b0;
    @(negedge clk);
    man_ack = 1'b1;
    @(negedge clk);
    man_ack = 1'b0;
    wait_idle(40);
    chk("glitch_hit_done", 32'(done_cnt - d0), 32'(1));
    chk("glitch_hit_err",  32'(err_cnt - e0), 32'(0));
    chk("drop_total",      32'(drop_cnt), 32'(1));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
